// File: rtl/multi_ch_ro_pkg.sv
// Shared definitions for the multi-channel readout controller:
// the state encoding, default parameter values and width helpers.
package multi_ch_ro_pkg;

    localparam int DEF_N_CH    = 4;
    localparam int DEF_SAMPLES = 256;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQ     = 2'd1,
        READY   = 2'd2,
        ZYNQ_RD = 2'd3
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // A single channel still needs a one-bit channel index.
    function automatic int ch_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/multi_ch_ro_ctrl_if.sv
// Per-channel FIFO strobes and empty flags between the readout
// controller (master) and the sample FIFO bank (slave).
interface multi_ch_ro_ctrl_if #(
    parameter int N_CH = 4
) ();
    logic [N_CH-1:0] fifo_wr_en;
    logic [N_CH-1:0] fifo_rd_en;
    logic [N_CH-1:0] fifo_empty;

    modport master (
        output fifo_wr_en,
        output fifo_rd_en,
        input  fifo_empty
    );

    modport slave (
        input  fifo_wr_en,
        input  fifo_rd_en,
        output fifo_empty
    );
endinterface

// File: rtl/ro_next_ch.sv
// Combinational priority finder: lowest set mask bit above the current
// channel, or the lowest set bit overall when first is high.
module ro_next_ch #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic [N_CH-1:0] mask,
    input  logic [CH_W-1:0] cur,
    input  logic            first,
    output logic [CH_W-1:0] nxt,
    output logic            none_left
);

    // Scanning downward lets the lowest qualifying bit win.
    always_comb begin
        nxt       = '0;
        none_left = 1'b1;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i] && (first || (i > int'(cur)))) begin
                nxt       = CH_W'(i);
                none_left = 1'b0;
            end
        end
    end

endmodule

// File: rtl/multi_ch_ro_ctrl.sv
// N-channel readout controller: captures a fixed-length window into every
// enabled FIFO on trigger, then drains the channels in ascending order.
module multi_ch_ro_ctrl
    import multi_ch_ro_pkg::*;
#(
    parameter  int N_CH    = DEF_N_CH,
    parameter  int SAMPLES = DEF_SAMPLES,
    parameter  int CNT_W   = DEF_CNT_W,
    localparam int CH_W    = ch_width(N_CH),
    localparam int SC_W    = clog2(SAMPLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trigger,
    input  logic             eos,
    input  logic [N_CH-1:0]  ch_en,
    input  logic             zynq_rd_rq,
    multi_ch_ro_ctrl_if.master fifo_if,
    output logic [CH_W-1:0]  rd_ch,
    output logic             evt_ready,
    output logic             busy,
    output logic [CNT_W-1:0] evt_cnt,
    output logic [CNT_W-1:0] missed_cnt
);

    localparam logic [SC_W-1:0] LAST = SC_W'(SAMPLES - 1);

    state_t           state, state_nxt;
    logic [SC_W-1:0]  samp_cnt, samp_nxt;
    logic [SC_W-1:0]  word_cnt, word_nxt;
    logic [N_CH-1:0]  ch_mask, mask_nxt;
    logic [CH_W-1:0]  rd_ch_nxt;
    logic [CNT_W-1:0] evt_nxt, missed_nxt;
    logic [CH_W-1:0]  first_ch, next_ch;
    logic             first_none, next_none;
    logic             cur_empty, ch_done;

    ro_next_ch #(.N_CH(N_CH), .CH_W(CH_W)) u_first (
        .mask(ch_mask), .cur(rd_ch), .first(1'b1),
        .nxt(first_ch), .none_left(first_none)
    );

    ro_next_ch #(.N_CH(N_CH), .CH_W(CH_W)) u_next (
        .mask(ch_mask), .cur(rd_ch), .first(1'b0),
        .nxt(next_ch), .none_left(next_none)
    );

    assign cur_empty = fifo_if.fifo_empty[rd_ch];

    always_comb begin
        state_nxt  = state;
        samp_nxt   = samp_cnt;
        word_nxt   = word_cnt;
        mask_nxt   = ch_mask;
        rd_ch_nxt  = rd_ch;
        evt_nxt    = evt_cnt;
        missed_nxt = missed_cnt;
        ch_done    = 1'b0;

        if (trigger && (state != IDLE) && (missed_cnt != '1)) begin
            missed_nxt = missed_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                if (trigger && (|ch_en)) begin
                    state_nxt = ACQ;
                    mask_nxt  = ch_en;
                    samp_nxt  = '0;
                end
            end
            ACQ: begin
                if (eos || (samp_cnt == LAST)) begin
                    state_nxt = READY;
                    samp_nxt  = '0;
                end else begin
                    samp_nxt = samp_cnt + 1'b1;
                end
            end
            READY: begin
                if (zynq_rd_rq) begin
                    state_nxt = first_none ? IDLE : ZYNQ_RD;
                    rd_ch_nxt = first_ch;
                    word_nxt  = '0;
                end
            end
            ZYNQ_RD: begin
                // An empty FIFO under an active request ends the channel at once,
                // which is how a window shortened by eos gets skipped.
                if (zynq_rd_rq) begin
                    ch_done = cur_empty || (word_cnt == LAST);
                    if (!cur_empty) word_nxt = word_cnt + 1'b1;
                    if (ch_done) begin
                        word_nxt = '0;
                        if (next_none) begin
                            state_nxt = IDLE;
                            evt_nxt   = evt_cnt + 1'b1;
                        end else begin
                            rd_ch_nxt = next_ch;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            samp_cnt   <= '0;
            word_cnt   <= '0;
            ch_mask    <= '0;
            rd_ch      <= '0;
            evt_cnt    <= '0;
            missed_cnt <= '0;
        end else begin
            state      <= state_nxt;
            samp_cnt   <= samp_nxt;
            word_cnt   <= word_nxt;
            ch_mask    <= mask_nxt;
            rd_ch      <= rd_ch_nxt;
            evt_cnt    <= evt_nxt;
            missed_cnt <= missed_nxt;
        end
    end

    always_comb begin
        fifo_if.fifo_rd_en = '0;
        if ((state == ZYNQ_RD) && zynq_rd_rq && !cur_empty) begin
            fifo_if.fifo_rd_en[rd_ch] = 1'b1;
        end
    end

    assign fifo_if.fifo_wr_en = (state == ACQ) ? ch_mask : '0;
    assign busy      = (state != IDLE);
    assign evt_ready = (state == READY) || (state == ZYNQ_RD);

endmodule

// File: tb/tb_multi_ch_ro_ctrl.sv
// Bench for multi_ch_ro_ctrl: an event/queue model of the readout flow is
// compared every cycle, with literal checks on window lengths and counts.
`timescale 1ns/100ps
module tb_multi_ch_ro_ctrl;

    localparam int N_CH    = 4;
    localparam int SAMPLES = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             trigger;
    logic             eos;
    logic [N_CH-1:0]  ch_en;
    logic             zynq_rd_rq;
    logic [1:0]       rd_ch;
    logic             evt_ready;
    logic             busy;
    logic [CNT_W-1:0] evt_cnt;
    logic [CNT_W-1:0] missed_cnt;

    multi_ch_ro_ctrl_if #(.N_CH(N_CH)) fi ();

    multi_ch_ro_ctrl #(.N_CH(N_CH), .SAMPLES(SAMPLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .trigger(trigger), .eos(eos), .ch_en(ch_en),
        .zynq_rd_rq(zynq_rd_rq), .fifo_if(fi), .rd_ch(rd_ch),
        .evt_ready(evt_ready), .busy(busy), .evt_cnt(evt_cnt), .missed_cnt(missed_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Event model: an acquisition in progress, an event held, and a queue
    // of channels still to be drained.
    bit              m_acq, m_held, m_reading;
    int              m_written, m_words, m_evt, m_missed;
    logic [N_CH-1:0] m_mask;
    int              m_q[$];

    int              occ[N_CH];
    logic [N_CH-1:0] pend_wr, pend_rd;
    int              wr_cycles;
    int              rd_words[N_CH];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic trg, input logic e, input logic [N_CH-1:0] en,
                                 input logic rq, input int n);
        trigger    = trg;
        eos        = e;
        ch_en      = en;
        zynq_rd_rq = rq;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearCounts();
        wr_cycles = 0;
        for (int i = 0; i < N_CH; i++) rd_words[i] = 0;
    endtask

    always @(posedge clk) begin : model_step
        int  ch;
        bit  done;
        if (!rst_n) begin
            m_acq = 0; m_held = 0; m_reading = 0;
            m_written = 0; m_words = 0; m_evt = 0; m_missed = 0;
            m_mask = '0;
            m_q.delete();
        end else begin
            if ((m_acq || m_held) && trigger) begin
                m_missed = (m_missed == CNT_MAX) ? CNT_MAX : m_missed + 1;
            end
            if (m_acq) begin
                m_written++;
                if (m_written == SAMPLES || eos) begin
                    m_acq  = 0;
                    m_held = 1;
                end
            end else if (m_reading) begin
                if (zynq_rd_rq) begin
                    ch = m_q[0];
                    if (fi.fifo_empty[ch]) begin
                        done = 1;
                    end else begin
                        m_words++;
                        done = (m_words == SAMPLES);
                    end
                    if (done) begin
                        void'(m_q.pop_front());
                        m_words = 0;
                        if (m_q.size() == 0) begin
                            m_reading = 0;
                            m_held    = 0;
                            m_evt     = (m_evt + 1) % (CNT_MAX + 1);
                        end
                    end
                end
            end else if (m_held) begin
                if (zynq_rd_rq) begin
                    m_reading = 1;
                    m_words   = 0;
                    for (int i = 0; i < N_CH; i++) if (m_mask[i]) m_q.push_back(i);
                end
            end else if (trigger && ch_en != '0) begin
                m_acq     = 1;
                m_written = 0;
                m_mask    = ch_en;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [N_CH-1:0] exp_wr, exp_rd;
        exp_wr = m_acq ? m_mask : '0;
        exp_rd = '0;
        if (m_reading && zynq_rd_rq && !fi.fifo_empty[m_q[0]]) exp_rd[m_q[0]] = 1'b1;
        checkOutput("fifo_wr_en", 32'(fi.fifo_wr_en), 32'(exp_wr));
        checkOutput("fifo_rd_en", 32'(fi.fifo_rd_en), 32'(exp_rd));
        checkOutput("busy",       32'(busy),          32'(m_acq || m_held));
        checkOutput("evt_ready",  32'(evt_ready),     32'(m_held));
        checkOutput("evt_cnt",    32'(evt_cnt),       32'(m_evt));
        checkOutput("missed_cnt", 32'(missed_cnt),    32'(m_missed));
        if (m_reading) checkOutput("rd_ch", 32'(rd_ch), 32'(m_q[0]));
        if (fi.fifo_wr_en != '0) wr_cycles++;
        for (int i = 0; i < N_CH; i++) rd_words[i] += int'(fi.fifo_rd_en[i]);
        pend_wr = fi.fifo_wr_en;
        pend_rd = fi.fifo_rd_en;
    end

    // Sample FIFO bank: occupancy follows the strobes of the cycle just ended.
    always @(posedge clk) begin : fifo_bank
        logic rst_seen;
        rst_seen = rst_n;
        #1;
        for (int i = 0; i < N_CH; i++) begin
            if (!rst_seen) occ[i] = 0;
            else begin
                occ[i] = occ[i] + int'(pend_wr[i]) - int'(pend_rd[i]);
                if (occ[i] < 0) occ[i] = 0;
            end
            fi.fifo_empty[i] = (occ[i] == 0);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N_CH; i++) occ[i] = 0;
        pend_wr = '0; pend_rd = '0;
        fi.fifo_empty = '1;
        rst_n = 1'b0;
        clearCounts();
        applyStimulus(0, 0, '0, 0, 3);
        rst_n = 1'b1;
        checkOutput("reset_busy",  32'(busy), 0);
        checkOutput("reset_wr_en", 32'(fi.fifo_wr_en), 0);
        checkOutput("reset_ready", 32'(evt_ready), 0);

        applyStimulus(0, 0, 4'hF, 0, 5);
        $display("[TB] full window, all channels");
        clearCounts();
        applyStimulus(1, 0, 4'hF, 0, 1);
        applyStimulus(0, 0, 4'hF, 0, 10);
        checkOutput("window_len", 32'(wr_cycles), 8);
        checkOutput("held_ready", 32'(evt_ready), 1);
        checkOutput("held_busy",  32'(busy), 1);
        clearCounts();
        applyStimulus(0, 0, 4'hF, 1, 40);
        for (int i = 0; i < N_CH; i++) checkOutput("words_full", 32'(rd_words[i]), 8);
        checkOutput("evt_after_1", 32'(evt_cnt), 1);
        checkOutput("idle_after_1", 32'(busy), 0);

        $display("[TB] eos window on channels 1 and 3");
        clearCounts();
        applyStimulus(1, 0, 4'b1010, 0, 1);
        applyStimulus(0, 0, 4'b1010, 0, 2);
        applyStimulus(0, 1, 4'b1010, 0, 1);
        applyStimulus(0, 0, 4'b0000, 0, 4);
        checkOutput("eos_window_len", 32'(wr_cycles), 3);
        clearCounts();
        applyStimulus(0, 0, 4'b0000, 1, 20);
        checkOutput("eos_ch0", 32'(rd_words[0]), 0);
        checkOutput("eos_ch1", 32'(rd_words[1]), 3);
        checkOutput("eos_ch2", 32'(rd_words[2]), 0);
        checkOutput("eos_ch3", 32'(rd_words[3]), 3);
        checkOutput("evt_after_2", 32'(evt_cnt), 2);

        $display("[TB] paused readout");
        clearCounts();
        applyStimulus(1, 0, 4'hF, 0, 3);
        applyStimulus(0, 0, 4'hF, 0, 8);
        checkOutput("missed_two", 32'(missed_cnt), 2);
        applyStimulus(0, 0, 4'hF, 1, 4);
        applyStimulus(0, 0, 4'hF, 0, 5);
        checkOutput("pause_rd_ch", 32'(rd_ch), 0);
        checkOutput("pause_words", 32'(rd_words[0]), 3);
        applyStimulus(0, 0, 4'hF, 1, 40);
        for (int i = 0; i < N_CH; i++) checkOutput("words_paused", 32'(rd_words[i]), 8);
        checkOutput("evt_after_3", 32'(evt_cnt), 3);

        $display("[TB] held trigger saturates missed count");
        applyStimulus(1, 0, 4'hF, 0, 40);
        checkOutput("missed_sat", 32'(missed_cnt), 15);
        checkOutput("sat_ready", 32'(evt_ready), 1);

        $display("[TB] reset during readout");
        applyStimulus(0, 0, 4'hF, 1, 5);
        rst_n = 1'b0;
        applyStimulus(0, 0, 4'hF, 0, 1);
        rst_n = 1'b1;
        checkOutput("rst_busy",   32'(busy), 0);
        checkOutput("rst_evt",    32'(evt_cnt), 0);
        checkOutput("rst_missed", 32'(missed_cnt), 0);
        checkOutput("rst_rd_ch",  32'(rd_ch), 0);
        clearCounts();
        applyStimulus(1, 0, 4'hF, 0, 1);
        applyStimulus(0, 0, 4'hF, 0, 10);
        checkOutput("post_rst_window", 32'(wr_cycles), 8);
        applyStimulus(0, 0, 4'hF, 1, 40);
        checkOutput("post_rst_evt", 32'(evt_cnt), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
